// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with branch redirect, stall hold,
// memory-wait bubbles and halt-on-HLT.
//
// Optional feature: define FETCH_PERF_CNT_EN to build the stall_cycles
// performance counter. Without it stall_cycles is tied to zero and no
// counter register exists.
//
// Ports
//   clk              in   single clock, rising edge
//   rst              in   synchronous active-high reset
//   stall            in   hazard hold, freezes PC and IF/ID write
//   branch_taken     in   redirect from decode
//   branch_target    in   redirect address
//   imem_addr        out  instruction memory address (= PC)
//   imem_req         out  fetch request (low while halted)
//   imem_data        in   fetched instruction
//   imem_valid       in   imem_data valid this cycle
//   instruction_out  out  instruction to IF/ID (NOP on flush/wait/halt)
//   oldPC_out        out  PC of instruction_out
//   newPC_out        out  oldPC_out + 2 (wraps modulo 2^16)
//   fd_wen           out  IF/ID write enable
//   halted           out  fetch stopped on HLT
//   stall_cycles     out  non-advancing cycle count
//
// state    | meaning
// ---------+------------------------------------------------------------
// RUN      | fetching normally, PC advances on each valid word
// WAIT_MEM | previous cycle had no valid word, bubble forwarded
// HALTED   | HLT accepted, no requests until branch or reset

module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] imem_addr,
  output logic        imem_req,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic [15:0] instruction_out,
  output logic [15:0] oldPC_out,
  output logic [15:0] newPC_out,
  output logic        fd_wen,
  output logic        halted,
  output logic [15:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    WAIT_MEM = 2'd1,
    HALTED   = 2'd2
  } state_t;

  localparam logic [3:0] HLT_OPCODE = 4'hF;

  state_t      state_q;
  state_t      state_next;
  logic [15:0] pc_q;
  logic [15:0] pc_next;
  logic [15:0] pc_plus2;
  logic        is_hlt;

  assign pc_plus2 = pc_q + 16'd2;
  assign is_hlt   = (imem_data[15:12] == HLT_OPCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_next;
      pc_q    <= pc_next;
    end
  end

  // Priority: branch redirect beats stall, stall beats fetch progress.
  always_comb begin
    state_next = state_q;
    pc_next    = pc_q;
    if (branch_taken) begin
      state_next = RUN;
      pc_next    = branch_target;
    end else if (!stall) begin
      case (state_q)
        RUN, WAIT_MEM: begin
          if (imem_valid) begin
            if (is_hlt) begin
              state_next = HALTED;
            end else begin
              state_next = RUN;
              pc_next    = pc_plus2;
            end
          end else begin
            state_next = WAIT_MEM;
          end
        end
        HALTED: begin
          state_next = HALTED;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_req  = (state_q != HALTED);
  assign oldPC_out = pc_q;
  assign newPC_out = pc_plus2;
  assign halted    = (state_q == HALTED);
  assign fd_wen    = (~stall) | branch_taken;

  // A stalled HLT is still forwarded; the halt only takes effect once
  // the stall releases and the word is presented again.
  assign instruction_out = (imem_valid && !branch_taken && (state_q != HALTED))
                         ? imem_data : NOP_INSTR;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cnt_q;
  logic        cnt_inc;

  assign cnt_inc = (pc_next == pc_q) && (state_q != HALTED) && !branch_taken
                 && (stall_cnt_q != 16'hFFFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'h0000;
    end else if (cnt_inc) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = 16'h0000;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000, bubble instruction driven on flush or memory wait.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 stall  input  1  hazard hold; freezes PC and IF/ID write.
REQ-006 branch_taken  input  1  redirect from decode.
REQ-007 branch_target  input  16  redirect address.
REQ-008 imem_addr  output  16  instruction memory address, equals current PC.
REQ-009 imem_req  output  1  fetch request.
REQ-010 imem_data  input  16  fetched instruction.
REQ-011 imem_valid  input  1  imem_data valid this cycle.
REQ-012 instruction_out  output  16  instruction to IF/ID register.
REQ-013 oldPC_out  output  16  PC of instruction_out.
REQ-014 newPC_out  output  16  oldPC_out + 2.
REQ-015 fd_wen  output  1  IF/ID register write enable.
REQ-016 halted  output  1  fetch stopped on HLT.
REQ-017 stall_cycles  output  16  non-advancing cycle count (see Configuration).

Function
REQ-018 States RUN, WAIT_MEM, HALTED; PC is a 16-bit register; all datapath outputs are combinational from PC, state and inputs.
REQ-019 imem_addr = PC at all times; imem_req = 1 in RUN and WAIT_MEM, 0 in HALTED.
REQ-020 oldPC_out = PC; newPC_out = PC + 2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
REQ-021 instruction_out = imem_data when imem_valid and not branch_taken and state != HALTED; otherwise NOP_INSTR.
REQ-022 fd_wen = (~stall) | branch_taken.
REQ-023 Priority per cycle: rst > branch_taken > stall > imem_valid/halt.
REQ-024 branch_taken in any state: PC <= branch_target, next state RUN, instruction_out = NOP_INSTR (flush).
REQ-025 stall without branch_taken: PC and state hold.
REQ-026 RUN, imem_valid, imem_data[15:12] != 4'hF: PC <= PC + 2, stay RUN.
REQ-027 RUN, imem_valid, imem_data[15:12] == 4'hF: PC holds, next state HALTED; the HLT instruction itself is forwarded this cycle.
REQ-028 RUN or WAIT_MEM, ~imem_valid: PC holds, next state WAIT_MEM, NOP_INSTR forwarded.
REQ-029 WAIT_MEM, imem_valid: behave exactly as RUN with imem_valid the same cycle (REQ-026/027).
REQ-030 HALTED: PC holds, halted = 1, NOP_INSTR forwarded; exits only on branch_taken or rst.
REQ-031 HLT fetched while stall = 1: no transition; HALTED entered on first non-stalled cycle with HLT still presented.

Reset
REQ-032 On clk edge with rst = 1: PC <= RESET_PC, state <= RUN, stall_cycles <= 0, regardless of state or other inputs.
REQ-033 After reset: imem_addr = RESET_PC, imem_req = 1, halted = 0.

Configuration
REQ-034 Macro FETCH_PERF_CNT_EN defined: stall_cycles increments by 1 each non-reset cycle where PC does not change and state != HALTED and branch_taken = 0, saturating at 16'hFFFF.
REQ-035 Macro FETCH_PERF_CNT_EN undefined: stall_cycles port present, driven constant 16'h0000, no counter register synthesized.

Verification
REQ-036 Reset, imem_valid = 1, data 16'h1234 each cycle -> imem_addr 0000, 0002, 0004; newPC_out = imem_addr + 2; fd_wen = 1.
REQ-037 PC = 0x0010, stall = 1 for 3 cycles -> PC stays 0x0010, fd_wen = 0; stall_cycles = 3 with macro, 0 without.
REQ-038 PC = 0x0020, imem_data = 16'hF000 -> HLT forwarded once, then halted = 1, imem_req = 0, PC = 0x0020, instruction_out = NOP_INSTR.
REQ-039 HALTED, branch_taken = 1, branch_target = 0x0100 -> next cycle RUN, imem_addr = 0x0100, halted = 0.
REQ-040 branch_taken = 1 and stall = 1 same cycle, target 0x0040 -> fd_wen = 1, instruction_out = NOP_INSTR, PC = 0x0040 next cycle.
REQ-041 PC = 0xFFFE, imem_valid = 1 -> newPC_out = 0x0000, next PC = 0x0000; imem_valid = 0 for 2 cycles mid-run -> WAIT_MEM, PC held, NOP forwarded, resumes on valid.
